// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake with a two-entry skid
// buffer so in_ready comes straight from a flop and never sees out_ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               CHANNELS  = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                occupancy
);

  localparam int DW = CHANNELS * WIDTH;

  logic [DW-1:0] rst_word;
  assign rst_word = {CHANNELS{RESET_VAL}};

  logic          main_v_q, main_v_d;
  logic [DW-1:0] main_d_q, main_d_d;
  logic          skid_v_q, skid_v_d;
  logic [DW-1:0] skid_d_q, skid_d_d;
  logic          in_ready_q, in_ready_d;

  logic accept;
  logic take;

  assign accept = in_valid & in_ready_q;
  assign take   = main_v_q & out_ready;

  // The skid entry is only ever filled while main is full, so an empty main
  // implies an empty skid and the first branch never has to consider skid.
  always_comb begin
    main_v_d   = main_v_q;
    main_d_d   = main_d_q;
    skid_v_d   = skid_v_q;
    skid_d_d   = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end
    end else if (take) begin
      if (skid_v_q) begin
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d_d = in_data;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d_d = in_data;
    end
    in_ready_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q   <= 1'b0;
      main_d_q   <= rst_word;
      skid_v_q   <= 1'b0;
      skid_d_q   <= rst_word;
      in_ready_q <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      main_d_q   <= main_d_d;
      skid_v_q   <= skid_v_d;
      skid_d_q   <= skid_d_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule
